alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//  64-bit two-stage pipelined integer ALU for the SMP execute stage.
//  - Ops: add/sub (64b and SIMD 32/16/8-bit lanes), logic, compares, shifts/rotates, byte swap, register swap.
//  - Secondary 64-bit output ex_result carries the upper half of dual-result ops (SWR, 128-bit lane ops).
//  - Accepts one op per cycle; fixed latency; no stalls.
// PARAMETERS
//  LEN_DATA      64  operand/result width (only 64 supported)
//  LEN_TYPE_ALU  5   opcode width
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  en         in   1   issue: op/operands valid this cycle
//  a          in   64  operand A
//  b          in   64  operand B (shift amount = b[5:0])
//  imm        in   64  immediate operand (128-bit lane ops only)
//  cin        in   8   carry in; only cin[0] used, cin[7:1] ignored
//  code       in   5   opcode
//  result     out  64  primary result
//  ex_result  out  64  secondary result
//  cout       out  1   carry out
//  rdy        out  1   result/ex_result/cout valid this cycle
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
//  Reset: result=0, ex_result=0, cout=0, rdy=0; both pipeline stages cleared; asserting rst mid-op discards in-flight ops.
//  Pipeline: stage 1 registers code/a/b/imm/cin[0]/en on edge N; stage 2 registers outputs on edge N+1.
//   - Latency 2 cycles; rdy on edge N+1 = en sampled at edge N.
//   - en=0 issues a bubble: rdy=0; result/ex_result/cout hold previous values.
//  Opcodes (decimal); all arithmetic mod 2^width, per-lane carries discarded, no saturation:
//   0 NOP: result=0, no update of cout
//   1 ADD64 a+b | 2 ADC64 a+b+cin | 3 ADD32 | 4 ADD16 | 5 ADD8 (lane-wise a+b)
//   6 SUB64 a-b | 7 RSB64 b-a | 8 SBC64 a-b+cin | 9 SUB32 | 10 SUB16 | 11 SUB8 (lane-wise a-b)
//   12 AND a&b | 13 EOR a^b | 14 ORR a|b | 19 MVN ~a
//   15 TST, 16 TEQ, 17 CMP, 18 CMN: result=0, ex_result=0
//   20 LSL a<<b[5:0] | 21 LSR a>>b[5:0] | 22 ASR arithmetic a>>>b[5:0]
//   23 RRX: 65-bit {cin,a} rotated right by b[5:0], low 64 bits
//   24 ROR: a rotated right by b[5:0] (shift 0 -> a)
//   25 BSWP: byte reverse of a (byte0<->byte7 ...)
//   26 SWR: result=b, ex_result=a
//   27 ADD128_BYTE: result=a+imm, ex_result=b+imm (8-bit lanes)
//   28 SUB128_BYTE: result=a-imm, ex_result=b-imm (8-bit lanes)
//   29 ADD128_TWOBYTE / 30 SUB128_TWOBYTE: as 27/28 in 16-bit lanes
//   31 reserved: result=0, ex_result=0, cout=0
//  ex_result=0 for every op not listed with one.
//  cout:
//   - ADD64/ADC64/CMN: carry out of bit 63.
//   - SUB64/SBC64/CMP: 1 = no borrow (a>=b unsigned); RSB64: 1 = b>=a.
//   - LSL: last bit shifted out; LSR/ASR/ROR/RRX: last bit shifted out right.
//   - Shift amount 0: cout=cin[0].
//   - All other ops: cout=0.
// CONFIGURATION
//  ALU_SIMD128_EN defined: opcodes 27-30 implemented as above.
//  ALU_SIMD128_EN undefined: 27-30 decode as reserved (result=0, ex_result=0, cout=0); lane-add logic for imm omitted.
// TESTING
//  - rst=1 mid-stream -> outputs 0, rdy=0 immediately. Release rst, then en=1, ADD64, a=b=0xFFFF_FFFF_FFFF_FFFF -> 2 cycles later result=0xFFFF_FFFF_FFFF_FFFE, cout=1, rdy=1.
//  - ADD8, a=0x01FF_0000_0000_0080, b=0x0101_0000_0000_0080 -> result=0x0200_0000_0000_0000 (no cross-lane carry).
//  - SUB64, a=5, b=7 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0. CMP, a=7, b=5 -> result=0, cout=1.
//  - ROR, a=0x1, b=1 -> result=0x8000_0000_0000_0000. BSWP, a=0x0102030405060708 -> 0x0807060504030201.
//  - SWR, a=0xA, b=0xB -> result=0xB, ex_result=0xA.
//  - ALU_SIMD128_EN, ADD128_BYTE, a=0x01, b=0x02, imm=0xFF -> result=0x00, ex_result=0x01.
//  - Back-to-back random ops, one per cycle, with en toggled -> each result 2 cycles after issue; rdy mirrors en delayed 2.

Source files
------------

// File: rtl/alu_core.sv
// Two-stage pipelined 64-bit ALU: add/sub (64b and SIMD lanes), logic, shifts, swaps.
// Define ALU_SIMD128_EN to enable the 128-bit lane ops (opcodes 27-30).
module alu_core #(
  parameter int LEN_DATA     = 64,
  parameter int LEN_TYPE_ALU = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [LEN_DATA-1:0]     a,
  input  logic [LEN_DATA-1:0]     b,
  input  logic [LEN_DATA-1:0]     imm,
  input  logic [7:0]              cin,
  input  logic [LEN_TYPE_ALU-1:0] code,
  output logic [LEN_DATA-1:0]     result,
  output logic [LEN_DATA-1:0]     ex_result,
  output logic                    cout,
  output logic                    rdy
);

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD64, OP_ADC64, OP_ADD32,
    OP_ADD16, OP_ADD8, OP_SUB64, OP_RSB64,
    OP_SBC64, OP_SUB32, OP_SUB16, OP_SUB8,
    OP_AND, OP_EOR, OP_ORR, OP_TST,
    OP_TEQ, OP_CMP, OP_CMN, OP_MVN,
    OP_LSL, OP_LSR, OP_ASR, OP_RRX,
    OP_ROR, OP_BSWP, OP_SWR, OP_A128B,
    OP_S128B, OP_A128H, OP_S128H, OP_RSVD
  } op_t;

  typedef struct packed {
    logic        en;
    op_t         code;
    logic [63:0] a;
    logic [63:0] b;
`ifdef ALU_SIMD128_EN
    logic [63:0] imm;
`endif
    logic        c;
  } s1_t;

  s1_t s1;

  logic unused_cin;
  assign unused_cin = ^cin[7:1];
`ifndef ALU_SIMD128_EN
  logic unused_imm;
  assign unused_imm = ^imm;
`endif

  // Lane-wise x+y+ci; w: 0=8b, 1=16b, else 32b lanes; lane carries dropped
  function automatic logic [63:0] lanes(
    input logic [63:0] x,
    input logic [63:0] y,
    input logic        ci,
    input logic [1:0]  w
  );
    logic [63:0] r;
    r = '0;
    case (w)
      2'd0:
        for (int i = 0; i < 8; i++)
          r[8*i +: 8] = x[8*i +: 8] + y[8*i +: 8] + {7'd0, ci};
      2'd1:
        for (int i = 0; i < 4; i++)
          r[16*i +: 16] = x[16*i +: 16] + y[16*i +: 16] + {15'd0, ci};
      default:
        for (int i = 0; i < 2; i++)
          r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32] + {31'd0, ci};
    endcase
    return r;
  endfunction

  logic [5:0]   n;
  logic [64:0]  add_w, adc_w, sub_w, rsb_w;
  logic [64:0]  lsl_w, lsr_w, asr_w;
  logic [127:0] ror_w;
  logic [129:0] rrx_w;
  logic [63:0]  r, e;
  logic         co, upd, sh_c;

  always_comb begin
    n     = s1.b[5:0];
    add_w = {1'b0, s1.a} + {1'b0, s1.b};
    adc_w = add_w + {64'd0, s1.c};
    sub_w = {1'b0, s1.a} + {1'b0, ~s1.b} + 65'd1;
    rsb_w = {1'b0, s1.b} + {1'b0, ~s1.a} + 65'd1;
    lsl_w = {1'b0, s1.a} << n;
    lsr_w = {s1.a, 1'b0} >> n;
    asr_w = $signed({s1.a, 1'b0}) >>> n;
    // doubling the operand turns a right shift into a rotate
    ror_w = {s1.a, s1.a} >> n;
    rrx_w = {s1.c, s1.a, s1.c, s1.a} >> n;
    sh_c  = (n == 6'd0) ? s1.c : lsr_w[0];
    r     = '0;
    e     = '0;
    co    = 1'b0;
    upd   = 1'b1;
    unique case (s1.code)
      OP_NOP:   upd = 1'b0;
      OP_ADD64: {co, r} = add_w;
      OP_ADC64: {co, r} = adc_w;
      OP_ADD32: r = lanes(s1.a, s1.b, 1'b0, 2'd2);
      OP_ADD16: r = lanes(s1.a, s1.b, 1'b0, 2'd1);
      OP_ADD8:  r = lanes(s1.a, s1.b, 1'b0, 2'd0);
      OP_SUB64: {co, r} = sub_w;
      OP_RSB64: {co, r} = rsb_w;
      OP_SBC64: begin
        r  = sub_w[63:0] + {63'd0, s1.c};
        co = sub_w[64];
      end
      OP_SUB32: r = lanes(s1.a, ~s1.b, 1'b1, 2'd2);
      OP_SUB16: r = lanes(s1.a, ~s1.b, 1'b1, 2'd1);
      OP_SUB8:  r = lanes(s1.a, ~s1.b, 1'b1, 2'd0);
      OP_AND:   r = s1.a & s1.b;
      OP_EOR:   r = s1.a ^ s1.b;
      OP_ORR:   r = s1.a | s1.b;
      OP_MVN:   r = ~s1.a;
      OP_CMP:   co = sub_w[64];
      OP_CMN:   co = add_w[64];
      OP_LSL: begin
        r  = lsl_w[63:0];
        co = (n == 6'd0) ? s1.c : lsl_w[64];
      end
      OP_LSR: begin r = lsr_w[64:1]; co = sh_c; end
      OP_ASR: begin r = asr_w[64:1]; co = sh_c; end
      OP_RRX: begin r = rrx_w[63:0]; co = sh_c; end
      OP_ROR: begin r = ror_w[63:0]; co = sh_c; end
      OP_BSWP:  r = {<<8{s1.a}};
      OP_SWR:   begin r = s1.b; e = s1.a; end
`ifdef ALU_SIMD128_EN
      OP_A128B: begin
        r = lanes(s1.a, s1.imm, 1'b0, 2'd0);
        e = lanes(s1.b, s1.imm, 1'b0, 2'd0);
      end
      OP_S128B: begin
        r = lanes(s1.a, ~s1.imm, 1'b1, 2'd0);
        e = lanes(s1.b, ~s1.imm, 1'b1, 2'd0);
      end
      OP_A128H: begin
        r = lanes(s1.a, s1.imm, 1'b0, 2'd1);
        e = lanes(s1.b, s1.imm, 1'b0, 2'd1);
      end
      OP_S128H: begin
        r = lanes(s1.a, ~s1.imm, 1'b1, 2'd1);
        e = lanes(s1.b, ~s1.imm, 1'b1, 2'd1);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      result    <= '0;
      ex_result <= '0;
      cout      <= 1'b0;
      rdy       <= 1'b0;
    end else begin
      s1.en   <= en;
      s1.code <= op_t'(code);
      s1.a    <= a;
      s1.b    <= b;
`ifdef ALU_SIMD128_EN
      s1.imm  <= imm;
`endif
      s1.c    <= cin[0];
      rdy     <= s1.en;
      if (s1.en) begin
        result    <= r;
        ex_result <= e;
        if (upd) cout <= co;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed known answers plus random issue with bubbles.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [63:0] a, b, imm;
  logic [7:0]  cin;
  logic [4:0]  code;
  logic [63:0] result, ex_result;
  logic        cout, rdy;

  alu_core dut (
    .clk(clk), .rst(rst), .en(en),
    .a(a), .b(b), .imm(imm),
    .cin(cin), .code(code),
    .result(result), .ex_result(ex_result),
    .cout(cout), .rdy(rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [63:0] res;
    logic [63:0] ex;
    logic        co;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_res, m_ex;
  logic        m_co;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] lane_m(input logic [63:0] x,
      input logic [63:0] y, input int lw, input bit sub);
    logic [63:0] r, m, xv, yv, lv;
    r = 0;
    m = (64'd1 << lw) - 64'd1;
    for (int s = 0; s < 64; s += lw) begin
      xv = (x >> s) & m;
      yv = (y >> s) & m;
      lv = sub ? xv - yv : xv + yv;
      r  = r | ((lv & m) << s);
    end
    return r;
  endfunction

  // Reference model; updates held outputs like the DUT's output register
  task automatic model(input logic [4:0] op, input logic [63:0] x,
      input logic [63:0] y, input logic [63:0] im, input logic c);
    logic [63:0] res, ex, t;
    logic [64:0] w, v;
    logic        co, upd;
    int          sh;
    res = 0; ex = 0; co = 0; upd = 1;
    sh = int'(y[5:0]);
    case (op)
      0:  upd = 0;
      1:  begin w = 65'(x) + 65'(y); res = w[63:0]; co = w[64]; end
      2:  begin w = 65'(x) + 65'(y) + 65'(c); res = w[63:0]; co = w[64]; end
      3:  res = lane_m(x, y, 32, 0);
      4:  res = lane_m(x, y, 16, 0);
      5:  res = lane_m(x, y, 8, 0);
      6:  begin res = x - y; co = (x >= y); end
      7:  begin res = y - x; co = (y >= x); end
      8:  begin res = x - y + 64'(c); co = (x >= y); end
      9:  res = lane_m(x, y, 32, 1);
      10: res = lane_m(x, y, 16, 1);
      11: res = lane_m(x, y, 8, 1);
      12: res = x & y;
      13: res = x ^ y;
      14: res = x | y;
      17: co = (x >= y);
      18: begin w = 65'(x) + 65'(y); co = w[64]; end
      19: res = ~x;
      20: begin t = x; co = c;
        for (int i = 0; i < sh; i++) begin co = t[63]; t = t << 1; end
        res = t; end
      21: begin t = x; co = c;
        for (int i = 0; i < sh; i++) begin co = t[0]; t = t >> 1; end
        res = t; end
      22: begin t = x; co = c;
        for (int i = 0; i < sh; i++) begin co = t[0]; t = {t[63], t[63:1]}; end
        res = t; end
      23: begin v = {c, x}; co = c;
        for (int i = 0; i < sh; i++) begin co = v[0]; v = {v[0], v[64:1]}; end
        res = v[63:0]; end
      24: begin t = x; co = c;
        for (int i = 0; i < sh; i++) begin co = t[0]; t = {t[0], t[63:1]}; end
        res = t; end
      25: res = {<<8{x}};
      26: begin res = y; ex = x; end
`ifdef ALU_SIMD128_EN
      27: begin res = lane_m(x, im, 8, 0);  ex = lane_m(y, im, 8, 0);  end
      28: begin res = lane_m(x, im, 8, 1);  ex = lane_m(y, im, 8, 1);  end
      29: begin res = lane_m(x, im, 16, 0); ex = lane_m(y, im, 16, 0); end
      30: begin res = lane_m(x, im, 16, 1); ex = lane_m(y, im, 16, 1); end
`endif
      default: ;
    endcase
    m_res = res;
    m_ex  = ex;
    if (upd) m_co = co;
  endtask

  // Drive one issue slot, compare the op that completes at this edge, queue this one
  task automatic cyc(input bit e, input logic [4:0] op, input logic [63:0] xa,
      input logic [63:0] xb, input logic [63:0] xi, input logic [7:0] xc);
    exp_t p;
    en = e; code = op; a = xa; b = xb; imm = xi; cin = xc;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      p = sb.pop_front();
      check("rdy", {63'd0, rdy}, {63'd0, p.en});
      check("result", result, p.res);
      check("ex_result", ex_result, p.ex);
      check("cout", {63'd0, cout}, {63'd0, p.co});
    end
    if (e) model(op, xa, xb, xi, xc[0]);
    p.en = e; p.res = m_res; p.ex = m_ex; p.co = m_co;
    sb.push_back(p);
  endtask

  task automatic expect_now(input string tag, input logic [63:0] r,
      input logic [63:0] x, input logic c);
    check({tag, "_res"}, result, r);
    check({tag, "_ex"}, ex_result, x);
    check({tag, "_cout"}, {63'd0, cout}, {63'd0, c});
  endtask

  task automatic one(input logic [4:0] op, input logic [63:0] xa,
      input logic [63:0] xb, input logic [63:0] xi, input logic [7:0] xc);
    cyc(1, op, xa, xb, xi, xc);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; en = 0; a = 0; b = 0; imm = 0; cin = 0; code = 0;
    m_res = 0; m_ex = 0; m_co = 0;
    @(negedge clk);
    @(negedge clk);
    expect_now("reset", 64'd0, 64'd0, 1'b0);
    check("reset_rdy", {63'd0, rdy}, 64'd0);
    rst = 0;

    cyc(1, 5'd1, 64'd3, 64'd4, 0, 0);
    cyc(1, 5'd26, 64'h55, 64'h66, 0, 0);
    cyc(1, 5'd13, 64'hF0F0, 64'h0FF0, 0, 0);
    rst = 1;
    #1;
    expect_now("rst_mid", 64'd0, 64'd0, 1'b0);
    check("rst_mid_rdy", {63'd0, rdy}, 64'd0);
    sb.delete();
    m_res = 0; m_ex = 0; m_co = 0;
    @(negedge clk);
    rst = 0;

    one(5'd1, '1, '1, 0, 8'hFE);
    expect_now("add64_ones", 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b1);
    one(5'd5, 64'h01FF_0000_0000_0080, 64'h0101_0000_0000_0080, 0, 0);
    expect_now("add8", 64'h0200_0000_0000_0000, 64'd0, 1'b0);
    one(5'd6, 64'd5, 64'd7, 0, 0);
    expect_now("sub64", 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0);
    one(5'd17, 64'd7, 64'd5, 0, 0);
    expect_now("cmp", 64'd0, 64'd0, 1'b1);
    one(5'd0, 64'd7, 64'd5, 0, 0);
    expect_now("nop_hold_cout", 64'd0, 64'd0, 1'b1);
    one(5'd24, 64'd1, 64'd1, 0, 0);
    expect_now("ror", 64'h8000_0000_0000_0000, 64'd0, 1'b1);
    one(5'd24, 64'h1234, 64'd0, 0, 8'h00);
    expect_now("ror0", 64'h1234, 64'd0, 1'b0);
    one(5'd25, 64'h0102_0304_0506_0708, 0, 0, 0);
    expect_now("bswp", 64'h0807_0605_0403_0201, 64'd0, 1'b0);
    one(5'd26, 64'hA, 64'hB, 0, 0);
    expect_now("swr", 64'hB, 64'hA, 1'b0);
    one(5'd20, 64'h8000_0000_0000_0001, 64'd1, 0, 0);
    expect_now("lsl1", 64'd2, 64'd0, 1'b1);
    one(5'd23, 64'd2, 64'd1, 0, 8'h01);
    expect_now("rrx1", 64'h8000_0000_0000_0001, 64'd0, 1'b0);
    one(5'd7, 64'd3, 64'd9, 0, 0);
    expect_now("rsb", 64'd6, 64'd0, 1'b1);
    one(5'd27, 64'h01, 64'h02, 64'hFF, 0);
`ifdef ALU_SIMD128_EN
    expect_now("add128b", 64'h00, 64'h01, 1'b0);
`else
    expect_now("add128b_rsvd", 64'h00, 64'h00, 1'b0);
`endif
    one(5'd31, '1, '1, '1, 8'hFF);
    expect_now("reserved", 64'd0, 64'd0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] ra, rb, ri;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      ri = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rb = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = rb;
      cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
          ra, rb, ri, 8'($urandom));
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
